// File: rtl/csr_issue_pkg.sv
// Shared CSR issue/execute definitions: physical register width, dispatch
// payload layout and the issue payload (exeparam) field map used by the
// execute stages.
package csr_issue_pkg;

  // Extra physical-register index bits beyond the 5 architectural ones
  localparam int unsigned RB         = 1;
  localparam int unsigned PRW        = 5 + RB;
  localparam int unsigned OPT_W      = 3;   // {rw, rs, rc}
  localparam int unsigned ZIMM_W     = 5;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned XLEN       = 64;

  // Issue payload {rw,rs,rc, rd0, op[63:0], addr}, LSB offsets
  localparam int unsigned EXE_ADDR_LSB    = 0;
  localparam int unsigned EXE_OP_LSB      = EXE_ADDR_LSB + CSR_ADDR_W;
  localparam int unsigned EXE_RD0_LSB     = EXE_OP_LSB + XLEN;
  localparam int unsigned EXE_OPT_LSB     = EXE_RD0_LSB + PRW;
  localparam int unsigned CSR_EXEPARAM_DW = EXE_OPT_LSB + OPT_W;

  // Dispatch payload without the trailing robtag (robtag width is a parameter)
  typedef struct packed {
    logic [OPT_W-1:0]      op_type;
    logic                  imm_sel;
    logic [ZIMM_W-1:0]     zimm;
    logic [PRW-1:0]        rd0;
    logic [PRW-1:0]        rs1;
    logic [CSR_ADDR_W-1:0] addr;
  } csr_info_t;

  localparam int unsigned CSR_INFO_W = $bits(csr_info_t);

endpackage

// File: rtl/csr_issue_fifo.sv
// Circular dispatch FIFO for CSR ops. Pointers carry a wrap bit in the MSB.
// Ports: CLK, RSTn, flush_i (clears pointers), push_i/wdata_i (write tail),
// pop_i (advance head), rdata_o (head entry, combinational),
// empty_o / full_o (decoded from registered pointers).
module csr_issue_fifo #(
  parameter int unsigned DP = 4,
  parameter int unsigned W  = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DP);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [W-1:0]  mem_q [DP];
  logic [W-1:0]  mem_d [DP];

  // Pointer update; flush wins over any push/pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
    end
  end

  gen_dffr #(.DW(PW)) u_wptr (.CLK(CLK), .RSTn(RSTn), .dnxt(wptr_d), .qout(wptr_q));
  gen_dffr #(.DW(PW)) u_rptr (.CLK(CLK), .RSTn(RSTn), .dnxt(rptr_d), .qout(rptr_q));

  // Entry write at the tail slot; validity comes from the pointers only
  always_comb begin
    for (int i = 0; i < int'(DP); i++) begin
      mem_d[i] = mem_q[i];
      if (push_i && (wptr_q[AW-1:0] == AW'(i))) mem_d[i] = wdata_i;
    end
  end

  for (genvar g = 0; g < int'(DP); g++) begin : g_ent
    gen_dffr #(.DW(W)) u_ent (.CLK(CLK), .RSTn(RSTn), .dnxt(mem_d[g]), .qout(mem_q[g]));
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/gen_dffr.sv
// Generic D flip-flop bank with asynchronous active-low reset.
// Ports: CLK, RSTn, dnxt (next value), qout (registered value).
module gen_dffr #(
  parameter int unsigned    DW      = 1,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) qout <= RST_VAL;
    else       qout <= dnxt;
  end

endmodule

// File: rtl/csr_issue.sv
// In-order CSR issue stage: buffers dispatched CSR ops and issues the head
// once it is the oldest ROB entry, its rs1 operand is ready (or it uses zimm)
// and the single-slot CSR execute unit is free.
// Ports: CLK, RSTn, beFlush; dispatch push (dptBuff_csr_vaild/_info,
// csr_buffer_full); operand lookup (csr_rs1_addr -> csr_rs1_rdy/_data);
// rob_oldest_tag; csr_writeback_vaild; registered issue (csr_exeparam_vaild,
// csr_exeparam).
module csr_issue
  import csr_issue_pkg::*;
#(
  parameter int unsigned DP   = 4,
  parameter int unsigned ROBW = 4,
  parameter int unsigned DW   = CSR_EXEPARAM_DW
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       beFlush,
  input  logic                       dptBuff_csr_vaild,
  input  logic [CSR_INFO_W+ROBW-1:0] dptBuff_csr_info,
  output logic                       csr_buffer_full,
  output logic [PRW-1:0]             csr_rs1_addr,
  input  logic                       csr_rs1_rdy,
  input  logic [XLEN-1:0]            csr_rs1_data,
  input  logic [ROBW-1:0]            rob_oldest_tag,
  input  logic                       csr_writeback_vaild,
  output logic                       csr_exeparam_vaild,
  output logic [DW-1:0]              csr_exeparam
);

  localparam int unsigned IW = CSR_INFO_W + ROBW;

  logic                       fifo_full, fifo_empty;
  logic [IW-1:0]              head;
  csr_info_t                  head_info;
  logic [ROBW-1:0]            head_tag;
  logic                       push, issue_ok;
  logic                       inflight_q, inflight_d;
  logic                       vld_q, vld_d;
  logic [DW-1:0]              exe_q, exe_d;
  logic [CSR_EXEPARAM_DW-1:0] exe_nxt;

  assign push = dptBuff_csr_vaild & ~fifo_full & ~beFlush;

  csr_issue_fifo #(.DP(DP), .W(IW)) u_fifo (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .flush_i (beFlush),
    .push_i  (push),
    .pop_i   (issue_ok),
    .wdata_i (dptBuff_csr_info),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head_tag  = head[ROBW-1:0];
  assign head_info = csr_info_t'(head[IW-1:ROBW]);

  assign csr_buffer_full = fifo_full;
  assign csr_rs1_addr    = fifo_empty ? '0 : head_info.rs1;

  // A writeback this cycle frees the execute slot for a back-to-back issue
  assign issue_ok = ~fifo_empty & (head_tag == rob_oldest_tag)
                  & (head_info.imm_sel | csr_rs1_rdy)
                  & (~inflight_q | csr_writeback_vaild) & ~beFlush;

  // Issue payload assembly
  always_comb begin
    exe_nxt = '0;
    exe_nxt[EXE_ADDR_LSB +: CSR_ADDR_W] = head_info.addr;
    exe_nxt[EXE_OP_LSB   +: XLEN]       = head_info.imm_sel ? XLEN'(head_info.zimm) : csr_rs1_data;
    exe_nxt[EXE_RD0_LSB  +: PRW]        = head_info.rd0;
    exe_nxt[EXE_OPT_LSB  +: OPT_W]      = head_info.op_type;
  end

  // Execute-slot occupancy, strobe and held payload
  always_comb begin
    inflight_d = inflight_q;
    vld_d      = issue_ok;
    exe_d      = exe_q;
    if (beFlush) begin
      inflight_d = 1'b0;
    end else if (issue_ok) begin
      inflight_d = 1'b1;
      exe_d      = DW'(exe_nxt);
    end else if (csr_writeback_vaild) begin
      inflight_d = 1'b0;
    end
  end

  gen_dffr #(.DW(1))  u_inflight (.CLK(CLK), .RSTn(RSTn), .dnxt(inflight_d), .qout(inflight_q));
  gen_dffr #(.DW(1))  u_vld      (.CLK(CLK), .RSTn(RSTn), .dnxt(vld_d),      .qout(vld_q));
  gen_dffr #(.DW(DW)) u_exe      (.CLK(CLK), .RSTn(RSTn), .dnxt(exe_d),      .qout(exe_q));

  assign csr_exeparam_vaild = vld_q;
  assign csr_exeparam       = exe_q;

endmodule

// File: tb/tb_csr_issue.sv
// Self-checking bench for csr_issue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_csr_issue;
  import csr_issue_pkg::*;

  localparam int DP   = 4;
  localparam int ROBW = 4;
  localparam int IW   = CSR_INFO_W + ROBW;
  localparam int DW   = CSR_EXEPARAM_DW;

  typedef struct packed {
    logic [2:0]  op_type;
    logic        imm;
    logic [4:0]  zimm;
    logic [5:0]  rd0;
    logic [5:0]  rs1;
    logic [11:0] addr;
    logic [3:0]  tag;
  } ent_t;

  logic            CLK, RSTn, beFlush, dptBuff_csr_vaild;
  logic [IW-1:0]   dptBuff_csr_info;
  logic            csr_buffer_full;
  logic [PRW-1:0]  csr_rs1_addr;
  logic            csr_rs1_rdy;
  logic [63:0]     csr_rs1_data;
  logic [ROBW-1:0] rob_oldest_tag;
  logic            csr_writeback_vaild;
  logic            csr_exeparam_vaild;
  logic [DW-1:0]   csr_exeparam;

  csr_issue #(.DP(DP), .ROBW(ROBW), .DW(DW)) dut (
    .CLK                 (CLK),
    .RSTn                (RSTn),
    .beFlush             (beFlush),
    .dptBuff_csr_vaild   (dptBuff_csr_vaild),
    .dptBuff_csr_info    (dptBuff_csr_info),
    .csr_buffer_full     (csr_buffer_full),
    .csr_rs1_addr        (csr_rs1_addr),
    .csr_rs1_rdy         (csr_rs1_rdy),
    .csr_rs1_data        (csr_rs1_data),
    .rob_oldest_tag      (rob_oldest_tag),
    .csr_writeback_vaild (csr_writeback_vaild),
    .csr_exeparam_vaild  (csr_exeparam_vaild),
    .csr_exeparam        (csr_exeparam)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  ent_t          mq[$];
  bit            m_infl;
  bit            m_vld;
  logic [DW-1:0] m_param;
  ent_t          cur;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_issues;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.op_type = 3'($urandom);
    e.imm     = 1'($urandom);
    e.zimm    = 5'($urandom);
    e.rd0     = 6'($urandom);
    e.rs1     = 6'($urandom);
    e.addr    = 12'($urandom);
    e.tag     = 4'($urandom);
    return e;
  endfunction

  function automatic logic [DW-1:0] exp_param(input ent_t e, input logic [63:0] d);
    logic [63:0] op;
    op = e.imm ? {59'b0, e.zimm} : d;
    return {e.op_type, e.rd0, op, e.addr};
  endfunction

  task automatic push(input ent_t e);
    cur               = e;
    dptBuff_csr_info  = IW'(e);
    dptBuff_csr_vaild = 1'b1;
  endtask

  task automatic idle();
    dptBuff_csr_vaild = 1'b0;
    beFlush           = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_infl  = 0;
    m_vld   = 0;
    m_param = '0;
  endtask

  // One clock: check combinational outputs, clock, then check registered ones
  task automatic cycle();
    bit          iss, psh, fl, wb;
    ent_t        h;
    logic [63:0] d;
    chk("full", csr_buffer_full, mq.size() == DP);
    if (mq.size() == 0) chk("rs1_addr", csr_rs1_addr, 0);
    else                chk("rs1_addr", csr_rs1_addr, mq[0].rs1);
    iss = 0;
    fl  = beFlush;
    wb  = csr_writeback_vaild;
    d   = csr_rs1_data;
    if (mq.size() > 0 && !fl) begin
      h   = mq[0];
      iss = (h.tag == rob_oldest_tag) && (h.imm || csr_rs1_rdy) && (!m_infl || wb);
    end
    psh = dptBuff_csr_vaild && (mq.size() < DP) && !fl;
    @(posedge CLK); #1;
    if (fl) begin
      mq.delete();
      m_infl = 0;
      m_vld  = 0;
    end else begin
      m_vld = iss;
      if (iss) begin
        h       = mq.pop_front();
        m_param = exp_param(h, d);
        m_infl  = 1;
        n_issues++;
      end else if (wb) begin
        m_infl = 0;
      end
      if (psh) mq.push_back(cur);
    end
    chk("vld", csr_exeparam_vaild, m_vld);
    chk("param", csr_exeparam, m_param);
  endtask

  initial begin
    ent_t e;
    RSTn = 0; beFlush = 0; dptBuff_csr_vaild = 0; dptBuff_csr_info = '0;
    csr_rs1_rdy = 0; csr_rs1_data = '0; rob_oldest_tag = '0; csr_writeback_vaild = 0;
    n_issues = 0;
    model_reset();
    #3;
    chk("rst_full", csr_buffer_full, 0);
    chk("rst_vld", csr_exeparam_vaild, 0);
    chk("rst_param", csr_exeparam, 0);
    @(posedge CLK); #1;
    RSTn = 1;
    cycle();

    // Immediate-operand op issues one cycle after reaching the head
    e = rnd_ent(); e.tag = 3; e.imm = 1; e.zimm = 5;
    rob_oldest_tag = 3; push(e); cycle();
    idle(); cycle();
    chk("t1_vld", csr_exeparam_vaild, 1);
    chk("t1_op", csr_exeparam[75:12], 64'h5);
    csr_writeback_vaild = 1; cycle(); csr_writeback_vaild = 0;

    // Operand wait, then issue with the register value
    e = rnd_ent(); e.tag = 7; e.imm = 0;
    rob_oldest_tag = 7; csr_rs1_rdy = 0; push(e); cycle(); idle();
    repeat (4) begin
      cycle();
      chk("t2_wait", csr_exeparam_vaild, 0);
    end
    csr_rs1_rdy = 1; csr_rs1_data = 64'hDEAD_BEEF; cycle();
    chk("t2_vld", csr_exeparam_vaild, 1);
    chk("t2_op", csr_exeparam[75:12], 64'hDEAD_BEEF);
    csr_rs1_rdy = 0; csr_writeback_vaild = 1; cycle(); csr_writeback_vaild = 0;

    // Fill, drop on full, drain in push order
    rob_oldest_tag = 15;
    for (int i = 0; i < 4; i++) begin
      e = rnd_ent(); e.tag = 4'(i); e.imm = 1; e.zimm = 5'(i + 1);
      push(e); cycle();
    end
    chk("t3_full", csr_buffer_full, 1);
    e = rnd_ent(); e.tag = 4; e.imm = 1; e.zimm = 5'd9;
    push(e); cycle(); idle();
    csr_writeback_vaild = 1; n_issues = 0;
    for (int i = 0; i < 4; i++) begin
      rob_oldest_tag = 4'(i); cycle();
      chk("t3_order", csr_exeparam[16:12], i + 1);
    end
    rob_oldest_tag = 4; cycle();
    chk("t3_dropped", csr_exeparam_vaild, 0);
    chk("t3_count", n_issues, 4);
    chk("t3_empty_full", csr_buffer_full, 0);
    csr_writeback_vaild = 0;

    // No second issue while the execute slot is busy
    e = rnd_ent(); e.tag = 5; e.imm = 1; push(e); cycle();
    e = rnd_ent(); e.tag = 6; e.imm = 1; rob_oldest_tag = 5; push(e); cycle();
    chk("t4_first", csr_exeparam_vaild, 1);
    idle(); rob_oldest_tag = 6;
    repeat (3) begin
      cycle();
      chk("t4_blocked", csr_exeparam_vaild, 0);
    end
    csr_writeback_vaild = 1; cycle();
    chk("t4_wb_issue", csr_exeparam_vaild, 1);
    cycle(); csr_writeback_vaild = 0;

    // Flush with entries and an op in flight
    rob_oldest_tag = 15;
    for (int i = 8; i < 12; i++) begin
      e = rnd_ent(); e.tag = 4'(i); e.imm = 1; push(e); cycle();
    end
    idle(); rob_oldest_tag = 8; cycle();
    e = rnd_ent(); e.tag = 12; e.imm = 1; push(e);
    beFlush = 1; rob_oldest_tag = 9; csr_writeback_vaild = 1; cycle();
    chk("t5_vld", csr_exeparam_vaild, 0);
    chk("t5_empty", csr_rs1_addr, 0);
    chk("t5_full", csr_buffer_full, 0);
    idle(); csr_writeback_vaild = 0;
    e = rnd_ent(); e.tag = 13; e.imm = 1; rob_oldest_tag = 13; push(e); cycle();
    idle(); cycle();
    chk("t5_infl_clr", csr_exeparam_vaild, 1);
    csr_writeback_vaild = 1; cycle(); csr_writeback_vaild = 0;

    // Wait for ROB order
    e = rnd_ent(); e.tag = 2; e.imm = 1; rob_oldest_tag = 1; push(e); cycle(); idle();
    repeat (3) begin
      cycle();
      chk("t6_wait", csr_exeparam_vaild, 0);
    end
    rob_oldest_tag = 2; cycle();
    chk("t6_vld", csr_exeparam_vaild, 1);
    csr_writeback_vaild = 1; cycle(); csr_writeback_vaild = 0;

    // Random traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        push(rnd_ent()); csr_rs1_rdy = 1;
        RSTn = 0; #2;
        chk("mid_rst_vld", csr_exeparam_vaild, 0);
        chk("mid_rst_full", csr_buffer_full, 0);
        chk("mid_rst_param", csr_exeparam, 0);
        model_reset();
        @(posedge CLK); #1;
        RSTn = 1; idle();
        cycle();
        chk("mid_rst_nostrobe", csr_exeparam_vaild, 0);
      end
      beFlush             = ($urandom_range(0, 99) < 3);
      dptBuff_csr_vaild   = ($urandom_range(0, 9) < 6);
      cur                 = rnd_ent();
      dptBuff_csr_info    = IW'(cur);
      csr_rs1_rdy         = 1'($urandom);
      csr_rs1_data        = {$urandom, $urandom};
      csr_writeback_vaild = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rob_oldest_tag = mq[0].tag;
      else                                           rob_oldest_tag = 4'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_issue.md
CSR_ISSUE -- requirements
Module: csr_issue

Interface
REQ-001 SHALL have parameter DP, default 4: dispatch buffer depth, power of two, at least 2.
REQ-002 SHALL have parameter ROBW, default 4: reorder-buffer tag width.
REQ-003 SHALL have parameter DW, default `CSR_EXEPARAM_DW: issue payload width, equal to 3+(5+`RB)+64+12.
REQ-004 SHALL have port CLK  input  1: single clock, rising edge.
REQ-005 SHALL have port RSTn  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port beFlush  input  1: synchronous pipeline flush.
REQ-007 SHALL have port dptBuff_csr_vaild  input  1: dispatch push request.
REQ-008 SHALL have port dptBuff_csr_info  input  3+1+5+2*(5+`RB)+12+ROBW: {rw,rs,rc, imm_sel, zimm[4:0], rd0, rs1, addr, robtag}.
REQ-009 SHALL have port csr_buffer_full  output  1: buffer cannot accept a push this cycle.
REQ-010 SHALL have port csr_rs1_addr  output  5+`RB: physical rs1 of the head entry.
REQ-011 SHALL have port csr_rs1_rdy  input  1: operand ready for csr_rs1_addr, same cycle.
REQ-012 SHALL have port csr_rs1_data  input  64: operand value for csr_rs1_addr, same cycle.
REQ-013 SHALL have port rob_oldest_tag  input  ROBW: tag of the oldest uncommitted instruction.
REQ-014 SHALL have port csr_writeback_vaild  input  1: the CSR execute stage has completed the op in flight.
REQ-015 SHALL have port csr_exeparam_vaild  output  1: registered issue strobe.
REQ-016 SHALL have port csr_exeparam  output  DW: registered {rw,rs,rc, rd0, op[63:0], addr}.

Function
REQ-017 SHALL hold entries in a circular FIFO with read and write pointers of log2(DP)+1 bits, the MSB being the wrap bit.
REQ-018 SHALL report empty when the pointers are equal.
REQ-019 SHALL report full when the low bits of the pointers are equal and the MSBs differ.
REQ-020 SHALL drive csr_buffer_full from the registered full state only; a pop in the same cycle SHALL NOT make room for that cycle's push.
REQ-021 SHALL accept a push when dptBuff_csr_vaild=1, the buffer is not full and beFlush=0; a push when full SHALL be dropped with no state change.
REQ-022 SHALL drive csr_rs1_addr from the head entry combinationally; when the buffer is empty it SHALL be 0.
REQ-023 SHALL define issue_ok as: not empty & head.robtag==rob_oldest_tag & (head.imm_sel | csr_rs1_rdy) & (~inflight | csr_writeback_vaild) & ~beFlush.
REQ-024 SHALL, when issue_ok=1, pop the head and register csr_exeparam_vaild=1 and csr_exeparam on the next edge, giving 1-cycle latency.
REQ-025 SHALL set op to {59'b0, zimm} when imm_sel=1, else to csr_rs1_data.
REQ-026 SHALL, when issue_ok=0, register csr_exeparam_vaild=0 and hold csr_exeparam at its previous value.
REQ-027 SHALL set an inflight flag on issue and clear it on csr_writeback_vaild without a new issue, so at most one CSR op is in execute at a time.
REQ-028 SHALL allow a writeback and a new issue in the same cycle, leaving inflight=1.
REQ-029 SHALL allow a push and a pop in the same cycle when the buffer is neither full nor empty, with the count unchanged.
REQ-030 SHALL wrap pointers modulo 2*DP.
REQ-031 SHALL, on beFlush=1, clear both pointers, inflight and csr_exeparam_vaild at the next edge, discard all entries, and ignore any push or issue in that cycle.

Reset
REQ-032 SHALL, on RSTn low, asynchronously zero the pointers, inflight, csr_exeparam_vaild and csr_exeparam.
REQ-033 SHALL drive csr_buffer_full=0 during and after reset.
REQ-034 SHALL NOT require entry storage to be reset; entries SHALL be qualified by the pointers only.
REQ-035 SHALL, on reset released mid-operation, restart empty with no spurious issue strobe.

Structure
REQ-036 SHALL place the payload field widths, field offsets and `CSR_EXEPARAM_DW in the shared define/package used by the execute stages.
REQ-037 SHALL implement all flops with the existing gen_dffr cell; the FIFO storage SHALL be one sub-module, csr_issue_fifo, holding the pointers and entries.

Verification
REQ-038 SHALL verify: reset; push tag 3 with imm_sel=1, zimm=5; rob_oldest_tag=3 -> next cycle csr_exeparam_vaild=1 and op=64'h5.
REQ-039 SHALL verify: head with rs1_rdy=0 for 4 cycles, then rdy=1 with data 64'hDEAD_BEEF -> one issue 1 cycle later carrying op=64'hDEAD_BEEF.
REQ-040 SHALL verify: 4 pushes with no issue -> csr_buffer_full=1; a 5th push is dropped; after draining, exactly 4 issues occur in push order.
REQ-041 SHALL verify: issue, no writeback for 3 cycles with the next head eligible -> no issue; writeback pulse -> issue in the same cycle, strobe on the next edge.
REQ-042 SHALL verify: 3 entries plus inflight, then assert beFlush -> next cycle empty, inflight=0, csr_exeparam_vaild=0, and a push in the flush cycle is ignored.
REQ-043 SHALL verify: head robtag=2, rob_oldest_tag=1 -> no issue; rob_oldest_tag changes to 2 -> issue on the next edge.
